// File: rtl/limbus_irq_ctrl_if.sv
// Avalon-MM slave bus bundle for the limbus interrupt controller.
// The CPU side drives address/strobes/write data and receives registered read data.
interface limbus_irq_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/limbus_irq_ctrl.sv
// Interrupt controller for the limbus interval timers and other request sources.
// Each request line is captured as level or rising edge into a sticky PENDING bit,
// PENDING is masked into one registered CPU interrupt, and software reaches the
// state through a small Avalon-MM register file (zero-wait writes, 1-cycle reads).
module limbus_irq_ctrl #(
    parameter int NUM_IRQ = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    limbus_irq_ctrl_if.slave    bus,
    input  logic [NUM_IRQ-1:0]  irq_in,
    output logic                irq
);

    // Word addresses of the register file.
    typedef enum logic [2:0] {
        REG_PENDING   = 3'd0,
        REG_MASK      = 3'd1,
        REG_EDGE_SEL  = 3'd2,
        REG_RAW       = 3'd3,
        REG_ACTIVE_ID = 3'd4,
        REG_FORCE     = 3'd5,
        REG_RSVD6     = 3'd6,
        REG_RSVD7     = 3'd7
    } reg_addr_e;

    reg_addr_e          addr;
    logic               wr;
    logic [NUM_IRQ-1:0] wdata;

    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] edge_sel;
    logic [NUM_IRQ-1:0] irq_in_d;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] set_vec;
    logic [NUM_IRQ-1:0] clr_vec;
    logic [NUM_IRQ-1:0] active;

    logic               active_valid;
    logic [3:0]         active_id;
    logic [15:0]        rdata_nxt;

    // Upper write-data bits are ignored when fewer than 16 lines are present.
    logic               unused_wdata_bits;

    assign addr  = reg_addr_e'(bus.address);
    assign wr    = bus.chipselect & ~bus.write_n;
    assign wdata = bus.writedata[NUM_IRQ-1:0];
    assign unused_wdata_bits = ^bus.writedata;

    // Capture terms: edge mode looks for a 0->1 step, level mode takes the line as is;
    // a FORCE write sets bits, a PENDING write clears them (set wins below).
    assign rise    = irq_in & ~irq_in_d;
    assign set_vec = (edge_sel & rise) | (~edge_sel & irq_in)
                   | ((wr && addr == REG_FORCE) ? wdata : '0);
    assign clr_vec = (wr && addr == REG_PENDING) ? wdata : '0;
    assign active  = pending & mask;

    // Register file, input history and sticky pending capture.
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would make results depend on statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending  <= '0;
            mask     <= '0;
            edge_sel <= '0;
            irq_in_d <= '0;
        end else begin
            irq_in_d <= irq_in;
            pending  <= set_vec | (pending & ~clr_vec);
            if (wr && addr == REG_MASK) begin
                mask <= wdata;
            end
            if (wr && addr == REG_EDGE_SEL) begin
                edge_sel <= wdata;
            end
        end
    end

    // Lowest-index active line wins; scan from the top so the last hit is the lowest.
    // NOTE: every output of a combinational block gets a default before any branch,
    // otherwise paths that skip an assignment infer a latch.
    always_comb begin
        active_valid = 1'b0;
        active_id    = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                active_valid = 1'b1;
                active_id    = 4'(i);
            end
        end
    end

    // Read mux; unused bits and reserved/write-only addresses read as zero.
    always_comb begin
        rdata_nxt = '0;
        case (addr)
            REG_PENDING:   rdata_nxt[NUM_IRQ-1:0] = pending;
            REG_MASK:      rdata_nxt[NUM_IRQ-1:0] = mask;
            REG_EDGE_SEL:  rdata_nxt[NUM_IRQ-1:0] = edge_sel;
            REG_RAW:       rdata_nxt[NUM_IRQ-1:0] = irq_in;
            REG_ACTIVE_ID: rdata_nxt = {active_valid, 11'b0, active_id};
            default:       rdata_nxt = '0;
        endcase
    end

    // Registered outputs: read data every cycle regardless of chipselect, and the CPU irq.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
            irq          <= 1'b0;
        end else begin
            bus.readdata <= rdata_nxt;
            irq          <= |active;
        end
    end

endmodule

// File: tb/tb_limbus_irq_ctrl.sv
// Self-checking bench for limbus_irq_ctrl: directed scenarios plus random traffic,
// all predicted by a register-level reference model and checked by a scoreboard.
module tb_limbus_irq_ctrl;

    localparam int          NUM_IRQ = 8;
    localparam int unsigned LMASK   = (1 << NUM_IRQ) - 1;

    logic               clk;
    logic               reset_n;
    logic [NUM_IRQ-1:0] irq_in;
    logic               irq;

    limbus_irq_ctrl_if bus_if ();

    limbus_irq_ctrl #(.NUM_IRQ(NUM_IRQ)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if),
        .irq_in  (irq_in),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] rd;
        logic        irq;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, kept as plain integers.
    int unsigned m_pending, m_mask, m_edge, m_prev;
    logic [NUM_IRQ-1:0] cur_in;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned model_active_id();
        int unsigned act;
        int unsigned id;
        act = m_pending & m_mask;
        if (act == 0) return 0;
        id = 0;
        while (((act >> id) & 1) == 0) id++;
        return 32'h8000 | id;
    endfunction

    task automatic model_reset();
        m_pending = 0;
        m_mask    = 0;
        m_edge    = 0;
        m_prev    = 0;
    endtask

    // Predict what one clock edge produces, then advance the model past that edge.
    task automatic model_step(input logic [2:0] a, input logic c, input logic w,
                              input logic [15:0] d, input logic [NUM_IRQ-1:0] in_v);
        exp_t        e;
        int unsigned inp, rise, setv, clrv, dv;
        logic        wr;
        inp = int'(in_v);
        dv  = int'(d) & LMASK;
        case (a)
            3'd0:    e.rd = 16'(m_pending);
            3'd1:    e.rd = 16'(m_mask);
            3'd2:    e.rd = 16'(m_edge);
            3'd3:    e.rd = 16'(inp);
            3'd4:    e.rd = 16'(model_active_id());
            default: e.rd = 16'h0000;
        endcase
        e.irq  = ((m_pending & m_mask) != 0);
        e.addr = a;
        exp_q.push_back(e);

        wr   = c && !w;
        rise = inp & ~m_prev;
        setv = (m_edge & rise) | (~m_edge & inp) | ((wr && a == 3'd5) ? dv : 0);
        clrv = (wr && a == 3'd0) ? dv : 0;
        m_pending = (setv | (m_pending & ~clrv)) & LMASK;
        if (wr && a == 3'd1) m_mask = dv;
        if (wr && a == 3'd2) m_edge = dv;
        m_prev = inp;
    endtask

    // One bus cycle: drive at the falling edge, return just after the rising edge.
    task automatic cycle(input logic [2:0] a, input logic c, input logic w, input logic [15:0] d);
        @(negedge clk);
        bus_if.address    = a;
        bus_if.chipselect = c;
        bus_if.write_n    = w;
        bus_if.writedata  = d;
        irq_in            = cur_in;
        model_step(a, c, w, d, cur_in);
        @(posedge clk);
        #2;
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
        cycle(a, 1'b1, 1'b0, d);
    endtask

    task automatic rd_reg(input logic [2:0] a);
        cycle(a, 1'b0, 1'b1, 16'h0000);
    endtask

    // Scoreboard monitor: one expectation per checked edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("sb_readdata[a=%0d]", e.addr), bus_if.readdata, e.rd);
                check("sb_irq", {15'b0, irq}, {15'b0, e.irq});
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n           = 1'b0;
        cur_in            = '0;
        irq_in            = '0;
        bus_if.address    = '0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #2;
        check("reset_readdata", bus_if.readdata, 16'h0000);
        check("reset_irq", {15'b0, irq}, 16'h0000);
        reset_n = 1'b1;

        // Level capture.
        wr_reg(3'd1, 16'h0001);
        cur_in = 8'h01;
        rd_reg(3'd0);
        rd_reg(3'd0);
        check("lvl_pending", bus_if.readdata, 16'h0001);
        check("lvl_irq", {15'b0, irq}, 16'h0001);
        wr_reg(3'd0, 16'h0001);
        rd_reg(3'd0);
        check("lvl_w1c_blocked", bus_if.readdata, 16'h0001);
        cur_in = 8'h00;
        wr_reg(3'd0, 16'h0001);
        rd_reg(3'd0);
        check("lvl_cleared", bus_if.readdata, 16'h0000);
        check("lvl_irq_low", {15'b0, irq}, 16'h0000);

        // Edge capture.
        wr_reg(3'd2, 16'h0002);
        wr_reg(3'd1, 16'h0002);
        cur_in = 8'h02;
        rd_reg(3'd0);
        cur_in = 8'h00;
        rd_reg(3'd0);
        rd_reg(3'd0);
        check("edge_pending_held", bus_if.readdata, 16'h0002);
        check("edge_irq", {15'b0, irq}, 16'h0001);
        wr_reg(3'd0, 16'h0002);
        rd_reg(3'd0);
        check("edge_cleared", bus_if.readdata, 16'h0000);
        check("edge_irq_low", {15'b0, irq}, 16'h0000);
        wr_reg(3'd2, 16'h0000);

        // Priority.
        wr_reg(3'd5, 16'h000A);
        wr_reg(3'd1, 16'h000A);
        rd_reg(3'd4);
        check("prio_id1", bus_if.readdata, 16'h8001);
        wr_reg(3'd1, 16'h0008);
        rd_reg(3'd4);
        check("prio_id3", bus_if.readdata, 16'h8003);
        wr_reg(3'd1, 16'h0000);
        rd_reg(3'd4);
        check("prio_none", bus_if.readdata, 16'h0000);
        check("prio_irq_low", {15'b0, irq}, 16'h0000);
        wr_reg(3'd0, 16'h00FF);

        // Set wins over clear in the same cycle.
        wr_reg(3'd2, 16'h0004);
        rd_reg(3'd0);
        cur_in = 8'h04;
        wr_reg(3'd0, 16'h0004);
        rd_reg(3'd0);
        check("set_beats_clr", bus_if.readdata & 16'h0004, 16'h0004);
        cur_in = 8'h00;
        wr_reg(3'd0, 16'h00FF);
        wr_reg(3'd2, 16'h0000);

        // FORCE and read latency.
        wr_reg(3'd1, 16'h0004);
        wr_reg(3'd5, 16'h0004);
        rd_reg(3'd0);
        check("force_pending", bus_if.readdata, 16'h0004);
        check("force_irq", {15'b0, irq}, 16'h0001);
        rd_reg(3'd5);
        check("force_reads_zero", bus_if.readdata, 16'h0000);
        wr_reg(3'd0, 16'h00FF);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [2:0]  a;
            logic        c, w;
            if ($urandom_range(0, 3) == 0) cur_in = NUM_IRQ'($urandom);
            a = 3'($urandom);
            c = ($urandom_range(0, 3) != 0);
            w = ($urandom_range(0, 2) != 0);
            cycle(a, c, w, 16'($urandom));
        end

        // Reset mid-operation.
        cur_in = 8'h00;
        wr_reg(3'd2, 16'h0000);
        wr_reg(3'd5, 16'h00FF);
        wr_reg(3'd1, 16'h00FF);
        rd_reg(3'd0);
        check("pre_reset_pending", bus_if.readdata, 16'h00FF);
        check("pre_reset_irq", {15'b0, irq}, 16'h0001);
        #1;
        bus_if.address    = 3'd1;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        bus_if.writedata  = 16'hFFFF;
        reset_n = 1'b0;
        #1;
        check("async_reset_readdata", bus_if.readdata, 16'h0000);
        check("async_reset_irq", {15'b0, irq}, 16'h0000);
        @(posedge clk);
        #2;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        model_reset();
        reset_n = 1'b1;
        rd_reg(3'd0);
        rd_reg(3'd1);
        check("post_reset_mask", bus_if.readdata, 16'h0000);
        rd_reg(3'd0);
        check("post_reset_pending", bus_if.readdata, 16'h0000);

        @(posedge clk);
        #2;
        check("sb_drained", 16'(exp_q.size()), 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
